// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the fetch/load-store memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int CPU_XLEN = 32;
    localparam int STRB_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [CPU_XLEN-1:0] adr;
        logic [CPU_XLEN-1:0] data;
        logic [STRB_W-1:0]   strobe;
        logic                we;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_prio2.sv
// ============================================================================
// Module      : mem_port_arbiter_prio2
// Description : Two-input fixed-priority arbiter; i_lo_force lets the
//               low-priority requester win a contested round.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter_prio2 (
    input  logic i_hi_req,
    input  logic i_lo_req,
    input  logic i_lo_force,
    output logic o_hi_gnt,
    output logic o_lo_gnt
);

    assign o_lo_gnt = i_lo_req & (~i_hi_req | i_lo_force);
    assign o_hi_gnt = i_hi_req & ~o_lo_gnt;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one cache_32x4 memory port between instruction fetch
//               and load/store, one transaction outstanding, with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = CPU_XLEN,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 64,
    parameter int TW         = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_v,
    input  logic [XLEN-1:0] i_adr,
    output logic            i_gnt,
    output logic [XLEN-1:0] i_resp,
    output logic            i_resp_v,
    input  logic            d_r_v,
    input  logic            d_w_v,
    input  logic [XLEN-1:0] d_adr,
    input  logic [XLEN-1:0] d_data,
    input  logic [3:0]      d_strobe,
    output logic            d_gnt,
    output logic [XLEN-1:0] d_resp,
    output logic            d_resp_v,
    output logic            m_r_v,
    output logic            m_w_v,
    output logic [XLEN-1:0] m_adr,
    output logic [XLEN-1:0] m_data,
    output logic [3:0]      m_strobe,
    input  logic [XLEN-1:0] m_resp,
    input  logic            m_resp_v,
    output logic            busy,
    output logic            err
);

    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0] c_streak_max = SW'(STREAK_MAX);
    localparam logic [TW-1:0] c_timer_last = TW'(TIMEOUT - 1);

    arb_state_t      r_state;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_timer;
    logic            r_err;
    logic            r_m_r_v;
    logic            r_m_w_v;
    mem_req_t        r_req;

    logic            w_idle;
    logic            w_wait;
    logic            w_d_req;
    logic            w_arb_i;
    logic            w_arb_d;
    logic            w_gnt_i;
    logic            w_gnt_d;
    logic            w_timeout;
    logic            w_done;
    mem_req_t        w_new_req;

    assign w_idle  = (r_state == IDLE);
    assign w_wait  = (r_state == WAIT_I) || (r_state == WAIT_D);
    assign w_d_req = d_r_v | d_w_v;

    // Data is the high-priority side; a saturated streak hands the round to fetch.
    mem_port_arbiter_prio2 u_prio (
        .i_hi_req   (w_d_req),
        .i_lo_req   (i_req_v),
        .i_lo_force (r_streak == c_streak_max),
        .o_hi_gnt   (w_arb_d),
        .o_lo_gnt   (w_arb_i)
    );

    assign w_gnt_i = w_idle & w_arb_i;
    assign w_gnt_d = w_idle & w_arb_d;
    assign i_gnt   = w_gnt_i;
    assign d_gnt   = w_gnt_d;

    // A response arriving on the last allowed cycle beats the timeout.
    assign w_timeout = w_wait & ~m_resp_v & (r_timer == c_timer_last);
    assign w_done    = w_wait & (m_resp_v | w_timeout);

    assign i_resp_v = (r_state == WAIT_I) & w_done;
    assign d_resp_v = (r_state == WAIT_D) & w_done;
    assign i_resp   = ((r_state == WAIT_I) && m_resp_v) ? m_resp : '0;
    assign d_resp   = ((r_state == WAIT_D) && m_resp_v && !r_req.we) ? m_resp : '0;

    // Simultaneous load and store requests are resolved as a store.
    always_comb begin
        w_new_req        = '0;
        w_new_req.adr    = i_adr;
        if (w_gnt_d) begin
            w_new_req.adr    = d_adr;
            w_new_req.we     = d_w_v;
            w_new_req.data   = d_w_v ? d_data : '0;
            w_new_req.strobe = d_w_v ? d_strobe : 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
            r_m_r_v  <= 1'b0;
            r_m_w_v  <= 1'b0;
            r_req    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_gnt_i || w_gnt_d) begin
                        r_req   <= w_new_req;
                        r_m_r_v <= ~w_new_req.we;
                        r_m_w_v <= w_new_req.we;
                        r_state <= w_gnt_i ? WAIT_I : WAIT_D;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (w_done) begin
                        r_m_r_v <= 1'b0;
                        r_m_w_v <= 1'b0;
                        r_timer <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Only contested data wins count toward the anti-starvation streak.
            if (w_gnt_i) begin
                r_streak <= '0;
            end else if (w_gnt_d && i_req_v && (r_streak != c_streak_max)) begin
                r_streak <= r_streak + 1'b1;
            end

            if (w_timeout || (d_r_v && d_w_v)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_r_v    = r_m_r_v;
    assign m_w_v    = r_m_w_v;
    assign m_adr    = r_req.adr;
    assign m_data   = r_req.data;
    assign m_strobe = r_req.strobe;
    assign busy     = ~w_idle;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               memory and an arbitration/data reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int STREAK_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic            clk;
    logic            rst;
    logic            i_req_v;
    logic [XLEN-1:0] i_adr;
    logic            i_gnt;
    logic [XLEN-1:0] i_resp;
    logic            i_resp_v;
    logic            d_r_v;
    logic            d_w_v;
    logic [XLEN-1:0] d_adr;
    logic [XLEN-1:0] d_data;
    logic [3:0]      d_strobe;
    logic            d_gnt;
    logic [XLEN-1:0] d_resp;
    logic            d_resp_v;
    logic            m_r_v;
    logic            m_w_v;
    logic [XLEN-1:0] m_adr;
    logic [XLEN-1:0] m_data;
    logic [3:0]      m_strobe;
    logic [XLEN-1:0] m_resp;
    logic            m_resp_v;
    logic            busy;
    logic            err;

    int checks = 0;
    int errors = 0;
    int tb_streak = 0;

    mem_port_arbiter #(
        .XLEN(XLEN), .STREAK_MAX(STREAK_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req_v(i_req_v), .i_adr(i_adr), .i_gnt(i_gnt), .i_resp(i_resp), .i_resp_v(i_resp_v),
        .d_r_v(d_r_v), .d_w_v(d_w_v), .d_adr(d_adr), .d_data(d_data), .d_strobe(d_strobe),
        .d_gnt(d_gnt), .d_resp(d_resp), .d_resp_v(d_resp_v),
        .m_r_v(m_r_v), .m_w_v(m_w_v), .m_adr(m_adr), .m_data(m_data), .m_strobe(m_strobe),
        .m_resp(m_resp), .m_resp_v(m_resp_v), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory (device side) and reference contents (model side).
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_arr [logic [31:0]];
    int          mem_lat;
    bit          mem_silent;
    logic        auto_v;
    logic [31:0] auto_d;
    logic        man_v;
    logic [31:0] man_d;

    assign m_resp_v = auto_v | man_v;
    assign m_resp   = auto_v ? auto_d : man_d;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rand_adr();
        return 32'h0000_1000 + ($urandom_range(0, 15) << 2);
    endfunction

    // Memory answers mem_lat cycles after it first sees a request strobe.
    initial begin
        int cnt;
        cnt = 0;
        auto_v = 1'b0;
        auto_d = '0;
        forever begin
            @(negedge clk);
            auto_v = 1'b0;
            auto_d = '0;
            if (rst || !(m_r_v || m_w_v)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (!mem_silent && cnt == mem_lat + 1) begin
                    auto_v = 1'b1;
                    if (m_w_v) begin
                        mem_arr[m_adr] = merge(mem_rd(m_adr), m_data, m_strobe);
                        auto_d = 32'hACAC_0000 | m_adr;
                    end else begin
                        auto_d = mem_rd(m_adr);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        i_req_v = 0; i_adr = '0; d_r_v = 0; d_w_v = 0; d_adr = '0; d_data = '0; d_strobe = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; clear_inputs(); man_v = 0; man_d = '0; mem_silent = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0; tb_streak = 0;
    endtask

    // Drives requests and checks every cycle against the arbitration rules.
    task automatic run_traffic(input int n, input bit contested, output string seq);
        int granted, cyc, wait_cnt, lat;
        bit busy_m, side_d, we, gave_i, gave_d, exp_gi, exp_gd, exp_rv, pend_i, pend_d;
        logic [31:0] adr, exp_d, wdata;
        logic [3:0]  exp_strb;
        granted = 0; cyc = 0; wait_cnt = 0; lat = 0; busy_m = 0; side_d = 0; we = 0;
        gave_i = 1; gave_d = 1; adr = '0; exp_d = '0; wdata = '0; exp_strb = '0;
        seq = "";
        while ((granted < n || busy_m) && cyc < n * 12 + 100) begin
            @(negedge clk);
            cyc++;
            if (gave_i || !i_req_v) begin
                if (granted < n && (contested || $urandom_range(0, 1) == 1)) begin
                    i_req_v = 1; i_adr = rand_adr();
                end else i_req_v = 0;
            end
            if (gave_d || !(d_r_v || d_w_v)) begin
                if (granted < n && (contested || $urandom_range(0, 1) == 1)) begin
                    d_w_v = ($urandom_range(0, 1) == 1); d_r_v = ~d_w_v;
                    d_adr = rand_adr(); d_data = $urandom; d_strobe = 4'($urandom_range(1, 15));
                end else begin
                    d_r_v = 0; d_w_v = 0;
                end
            end
            gave_i = 0; gave_d = 0;
            #1;
            pend_i = i_req_v; pend_d = d_r_v | d_w_v;
            exp_gi = 0; exp_gd = 0;
            if (!busy_m) begin
                if (pend_i && pend_d) begin
                    if (tb_streak == STREAK_MAX) exp_gi = 1; else exp_gd = 1;
                end else begin
                    exp_gi = pend_i; exp_gd = pend_d;
                end
            end
            checks++;
            if ({i_gnt, d_gnt} !== {exp_gi, exp_gd}) begin
                errors++;
                $display("FAIL traffic_gnt cyc %0d: got i=%b d=%b want i=%b d=%b", cyc, i_gnt, d_gnt, exp_gi, exp_gd);
            end
            if (exp_gi || exp_gd) begin
                if (exp_gi) tb_streak = 0;
                else if (pend_i && tb_streak < STREAK_MAX) tb_streak++;
                if (exp_gi) seq = {seq, "I"}; else seq = {seq, "D"};
                side_d = exp_gd; we = exp_gd && d_w_v;
                adr = exp_gd ? d_adr : i_adr;
                wdata = d_data; exp_strb = we ? d_strobe : 4'h0;
                if (we) begin
                    ref_arr[adr] = merge(ref_rd(adr), d_data, d_strobe);
                    exp_d = '0;
                end else exp_d = ref_rd(adr);
                lat = $urandom_range(0, 4); mem_lat = lat;
                wait_cnt = 0; busy_m = 1; granted++;
                gave_i = exp_gi; gave_d = exp_gd;
            end else if (busy_m) begin
                wait_cnt++;
                exp_rv = (wait_cnt == lat + 1);
                checks++;
                if ({i_resp_v, d_resp_v} !== {exp_rv && !side_d, exp_rv && side_d}) begin
                    errors++;
                    $display("FAIL traffic_resp_v cyc %0d: got i=%b d=%b want i=%b d=%b", cyc, i_resp_v, d_resp_v, exp_rv && !side_d, exp_rv && side_d);
                end
                checks++;
                if (m_r_v !== !we || m_w_v !== we || m_adr !== adr || m_strobe !== exp_strb || (we && m_data !== wdata)) begin
                    errors++;
                    $display("FAIL traffic_bus cyc %0d: got r=%b w=%b adr=%h strb=%h data=%h want r=%b w=%b adr=%h strb=%h data=%h",
                             cyc, m_r_v, m_w_v, m_adr, m_strobe, m_data, !we, we, adr, exp_strb, wdata);
                end
                if (exp_rv) begin
                    checks++;
                    if ((side_d ? d_resp : i_resp) !== exp_d) begin
                        errors++;
                        $display("FAIL traffic_data cyc %0d: got %h want %h", cyc, side_d ? d_resp : i_resp, exp_d);
                    end
                    busy_m = 0;
                end
            end
        end
        checks++;
        if (granted < n || busy_m) begin
            errors++;
            $display("FAIL traffic_bound: got %0d grants want %0d", granted, n);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({busy, err, m_r_v, m_w_v} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got busy=%b err=%b r=%b w=%b want 0", busy, err, m_r_v, m_w_v);
        end
        checks++;
        if (m_adr !== '0 || m_data !== '0 || m_strobe !== 4'h0) begin
            errors++; $display("FAIL reset_bus: got adr=%h data=%h strb=%h want 0", m_adr, m_data, m_strobe);
        end
        checks++;
        if ({i_gnt, d_gnt, i_resp_v, d_resp_v} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b want 0000", {i_gnt, d_gnt, i_resp_v, d_resp_v});
        end
        @(negedge clk);
        rst = 0; tb_streak = 0;
    endtask

    task automatic test_fetch();
        mem_arr[32'h10004] = 32'hDEADBEEF; ref_arr[32'h10004] = 32'hDEADBEEF; mem_lat = 1;
        @(negedge clk);
        i_req_v = 1; i_adr = 32'h10004;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++; $display("FAIL fetch_gnt: got i=%b d=%b want i=1 d=0", i_gnt, d_gnt);
        end
        @(negedge clk);
        i_req_v = 0;
        #1;
        checks++;
        if (m_r_v !== 1'b1 || m_w_v !== 1'b0 || m_adr !== 32'h10004 || m_strobe !== 4'h0 || busy !== 1'b1 || i_resp_v !== 1'b0) begin
            errors++; $display("FAIL fetch_req: got r=%b w=%b adr=%h strb=%h busy=%b rv=%b want 1 0 10004 0 1 0", m_r_v, m_w_v, m_adr, m_strobe, busy, i_resp_v);
        end
        @(negedge clk);
        #1;
        checks++;
        if (i_resp_v !== 1'b1 || i_resp !== 32'hDEADBEEF || d_resp_v !== 1'b0) begin
            errors++; $display("FAIL fetch_resp: got v=%b data=%h dv=%b want 1 deadbeef 0", i_resp_v, i_resp, d_resp_v);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_r_v !== 1'b0 || i_resp_v !== 1'b0) begin
            errors++; $display("FAIL fetch_idle: got busy=%b r=%b rv=%b want 0 0 0", busy, m_r_v, i_resp_v);
        end
    endtask

    task automatic test_store();
        bit got;
        got = 0; mem_lat = 3;
        @(negedge clk);
        d_w_v = 1; d_adr = 32'h20008; d_data = 32'h11223344; d_strobe = 4'hF;
        #1;
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++; $display("FAIL store_gnt: got i=%b d=%b want i=0 d=1", i_gnt, d_gnt);
        end
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            d_w_v = 0; d_adr = '0; d_data = '0; d_strobe = '0;
            #1;
            checks++;
            if (m_w_v !== 1'b1 || m_r_v !== 1'b0 || m_adr !== 32'h20008 || m_data !== 32'h11223344 || m_strobe !== 4'hF) begin
                errors++; $display("FAIL store_hold: got w=%b r=%b adr=%h data=%h strb=%h", m_w_v, m_r_v, m_adr, m_data, m_strobe);
            end
            checks++;
            if (i_resp_v !== 1'b0) begin
                errors++; $display("FAIL store_no_iresp: got %b want 0", i_resp_v);
            end
            if (d_resp_v === 1'b1) begin
                got = 1;
                checks++;
                if (d_resp !== '0 || k != 3) begin
                    errors++; $display("FAIL store_ack: got data=%h at %0d want 0 at 3", d_resp, k);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL store_ack_missing: got no d_resp_v want one");
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_w_v !== 1'b0 || mem_rd(32'h20008) !== 32'h11223344) begin
            errors++; $display("FAIL store_done: got w=%b mem=%h want 0 11223344", m_w_v, mem_rd(32'h20008));
        end
        ref_arr[32'h20008] = 32'h11223344;
    endtask

    task automatic test_streak();
        string seq;
        string want;
        want = "DDDDIDDDDIDD";
        run_traffic(12, 1'b1, seq);
        checks++;
        if (seq != want) begin
            errors++; $display("FAIL streak_seq: got %s want %s", seq, want);
        end
    endtask

    task automatic test_reset_abort();
        string seq;
        string want;
        want = "DDDDI";
        mem_silent = 1;
        @(negedge clk);
        i_req_v = 1; i_adr = 32'h1040;
        #1;
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++; $display("FAIL abort_gnt: got %b want 1", i_gnt);
        end
        @(negedge clk);
        i_req_v = 0; rst = 1;
        #1;
        checks++;
        if (busy !== 1'b1 || m_r_v !== 1'b1) begin
            errors++; $display("FAIL abort_wait: got busy=%b r=%b want 1 1", busy, m_r_v);
        end
        @(negedge clk);
        rst = 0; man_v = 1; man_d = 32'h12345678;
        #1;
        checks++;
        if (i_resp_v !== 1'b0 || d_resp_v !== 1'b0 || m_r_v !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL abort_state: got rv=%b dv=%b r=%b busy=%b err=%b want all 0", i_resp_v, d_resp_v, m_r_v, busy, err);
        end
        @(negedge clk);
        man_v = 0; man_d = '0; mem_silent = 0; tb_streak = 0;
        run_traffic(5, 1'b1, seq);
        checks++;
        if (seq != want) begin
            errors++; $display("FAIL abort_streak: got %s want %s", seq, want);
        end
    endtask

    task automatic test_timeout_boundary();
        int at;
        logic [31:0] exp;
        at = -1; exp = ref_rd(32'h1080); mem_lat = TIMEOUT - 1;
        @(negedge clk);
        d_r_v = 1; d_adr = 32'h1080;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL tob_gnt: got %b want 1", d_gnt);
        end
        for (int k = 1; k <= TIMEOUT + 4 && at < 0; k++) begin
            @(negedge clk);
            d_r_v = 0; d_adr = '0;
            #1;
            if (d_resp_v === 1'b1) begin
                at = k;
                checks++;
                if (d_resp !== exp) begin
                    errors++; $display("FAIL tob_data: got %h want %h", d_resp, exp);
                end
            end
        end
        checks++;
        if (at != TIMEOUT) begin
            errors++; $display("FAIL tob_cycle: got %0d want %0d", at, TIMEOUT);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL tob_noerr: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_timeout();
        int at;
        bit irv;
        logic [31:0] exp;
        at = -1; irv = 0; mem_silent = 1;
        @(negedge clk);
        d_r_v = 1; d_adr = 32'h20000;
        #1;
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++; $display("FAIL to_gnt: got %b want 1", d_gnt);
        end
        for (int k = 1; k <= TIMEOUT + 4 && at < 0; k++) begin
            @(negedge clk);
            d_r_v = 0; d_adr = '0;
            #1;
            if (i_resp_v === 1'b1) irv = 1;
            if (d_resp_v === 1'b1) begin
                at = k;
                checks++;
                if (d_resp !== '0) begin
                    errors++; $display("FAIL to_data: got %h want 0", d_resp);
                end
            end
        end
        checks++;
        if (at != TIMEOUT || irv) begin
            errors++; $display("FAIL to_cycle: got %0d irv=%b want %0d irv=0", at, irv, TIMEOUT);
        end
        @(negedge clk);
        mem_silent = 0; mem_lat = 2;
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_err: got err=%b busy=%b want 1 0", err, busy);
        end
        exp = ref_rd(32'h1010); at = -1;
        @(negedge clk);
        i_req_v = 1; i_adr = 32'h1010;
        for (int k = 1; k <= 10 && at < 0; k++) begin
            @(negedge clk);
            i_req_v = 0;
            #1;
            if (i_resp_v === 1'b1) begin
                at = k;
                checks++;
                if (i_resp !== exp || d_resp_v !== 1'b0) begin
                    errors++; $display("FAIL to_fetch_data: got %h dv=%b want %h 0", i_resp, d_resp_v, exp);
                end
            end
        end
        checks++;
        if (at != 3) begin
            errors++; $display("FAIL to_fetch_cycle: got %0d want 3", at);
        end
    endtask

    task automatic test_rw_both();
        bit got;
        got = 0; mem_lat = 1;
        do_reset();
        @(negedge clk);
        d_r_v = 1; d_w_v = 1; d_adr = 32'h1100; d_data = 32'hCAFEF00D; d_strobe = 4'b0011;
        #1;
        checks++;
        if (d_gnt !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL rw_gnt: got gnt=%b err=%b want 1 0", d_gnt, err);
        end
        ref_arr[32'h1100] = merge(ref_rd(32'h1100), 32'hCAFEF00D, 4'b0011);
        @(negedge clk);
        d_r_v = 0; d_w_v = 0;
        #1;
        checks++;
        if (m_w_v !== 1'b1 || m_r_v !== 1'b0 || m_strobe !== 4'b0011 || err !== 1'b1) begin
            errors++; $display("FAIL rw_bus: got w=%b r=%b strb=%h err=%b want 1 0 3 1", m_w_v, m_r_v, m_strobe, err);
        end
        for (int k = 0; k < 6 && !got; k++) begin
            if (d_resp_v === 1'b1) begin
                got = 1;
                checks++;
                if (d_resp !== '0) begin
                    errors++; $display("FAIL rw_ack: got %h want 0", d_resp);
                end
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!got || err !== 1'b1 || mem_rd(32'h1100) !== ref_rd(32'h1100)) begin
            errors++; $display("FAIL rw_sticky: got ack=%b err=%b mem=%h want 1 1 %h", got, err, mem_rd(32'h1100), ref_rd(32'h1100));
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL rw_clear: got err=%b want 0", err);
        end
    endtask

    task automatic test_random();
        string seq;
        do_reset();
        run_traffic(40, 1'b0, seq);
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL random_end: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; clear_inputs(); mem_lat = 1; mem_silent = 0; man_v = 0; man_d = '0;
        test_reset();
        test_fetch();
        test_store();
        test_streak();
        test_reset_abort();
        test_timeout_boundary();
        test_timeout();
        test_rw_both();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
